sine_nco: RTL and testbench

Numerically controlled sine oscillator that produces one signed audio sample per LR-clock period, for the DAC channel inputs of the I2S transmitter. It takes the place of the free-running sawtooth counter in the top level. It runs on the master oscillator clock and detects rising edges of the LR clock internally. It generates samples through a phase accumulator, a quarter-wave sine ROM and an optional amplitude scaler.

---
 rtl/sine_nco.sv | 167 ++++++++++++++++
 tb/tb_sine_nco.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sine_nco.sv
// sine_nco: phase-accumulator sine oscillator, one signed sample per rising edge of lrclk.
// Define SINE_NCO_AMP_EN to add the amp/256 scaler stage (latency 5 instead of 4).
module sine_nco #(
  parameter int BITSIZE    = 16,
  parameter int PHASE_BITS = 24,
  parameter int LUT_BITS   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      lrclk,
  input  logic [PHASE_BITS-1:0]     freq_word,
  input  logic [7:0]                amp,
  input  logic                      phase_clr,
  output logic signed [BITSIZE-1:0] sample,
  output logic                      sample_valid
);

  localparam int  LUT_SIZE   = 2 ** LUT_BITS;
  localparam int  TOP_BITS   = LUT_BITS + 2;
  localparam real PI         = 3.14159265358979323846;
  localparam real FULL_SCALE = $itor(2 ** (BITSIZE - 1) - 1);

  // Quarter-wave table sampled at bin centres, so mirrored quadrants join without a repeated entry.
  // NOTE: the table is a constant set at elaboration; it has no state, so it needs no reset.
  logic [BITSIZE-2:0] rom_tbl [LUT_SIZE];
  for (genvar i = 0; i < LUT_SIZE; i++) begin : g_rom
    localparam real ANGLE = PI / 2.0 * ($itor(i) + 0.5) / $itor(LUT_SIZE);
    localparam int  ENTRY = $rtoi(FULL_SCALE * $sin(ANGLE) + 0.5);
    assign rom_tbl[i] = ENTRY[BITSIZE-2:0];
  end

  // A tick needs lrclk seen low after reset, so lrclk held high out of reset produces nothing.
  logic lrclk_q;
  logic lrclk_armed;
  logic tick;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lrclk_q     <= 1'b0;
      lrclk_armed <= 1'b0;
      tick        <= 1'b0;
    end else begin
      lrclk_q <= lrclk;
      if (!lrclk) lrclk_armed <= 1'b1;
      tick    <= lrclk && !lrclk_q && lrclk_armed;
    end
  end

  // S1: capture phase (only the bits the table lookup needs) and advance the accumulator.
  logic [PHASE_BITS-1:0] phase;
  logic [PHASE_BITS-1:0] cur_phase;
  logic [TOP_BITS-1:0]   s1_top;
  logic                  s1_valid;

  assign cur_phase = phase_clr ? '0 : phase;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase    <= '0;
      s1_top   <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= tick;
      if (tick) begin
        phase  <= cur_phase + freq_word;
        s1_top <= cur_phase[PHASE_BITS-1 -: TOP_BITS];
      end
    end
  end

  // S2: quadrant decode, odd quadrants walk the table backwards.
  logic [1:0]          s1_quad;
  logic [LUT_BITS-1:0] s1_addr;
  logic [LUT_BITS-1:0] s2_addr;
  logic                s2_neg;
  logic                s2_valid;

  assign s1_quad = s1_top[TOP_BITS-1 -: 2];
  assign s1_addr = s1_top[LUT_BITS-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_addr  <= '0;
      s2_neg   <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      s2_addr  <= s1_quad[0] ? ~s1_addr : s1_addr;
      s2_neg   <= s1_quad[1];
      s2_valid <= s1_valid;
    end
  end

  // S3: registered table read.
  logic [BITSIZE-2:0] s3_rom;
  logic               s3_neg;
  logic               s3_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s3_rom   <= '0;
      s3_neg   <= 1'b0;
      s3_valid <= 1'b0;
    end else begin
      s3_rom   <= rom_tbl[s2_addr];
      s3_neg   <= s2_neg;
      s3_valid <= s2_valid;
    end
  end

  // S4: apply sign; magnitude never exceeds 2^(BITSIZE-1)-1 so negation cannot overflow.
  logic signed [BITSIZE-1:0] rom_ext;
  logic signed [BITSIZE-1:0] s_signed;

  assign rom_ext  = {1'b0, s3_rom};
  assign s_signed = s3_neg ? -rom_ext : rom_ext;

`ifdef SINE_NCO_AMP_EN
  logic [7:0]                s1_amp, s2_amp, s3_amp, s4_amp;
  logic signed [BITSIZE-1:0] s4_sample;
  logic                      s4_valid;
  logic signed [BITSIZE+8:0] s_ext, a_ext, prod;
  logic                      unused_prod_bits;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_amp       <= '0;
      s2_amp       <= '0;
      s3_amp       <= '0;
      s4_amp       <= '0;
      s4_sample    <= '0;
      s4_valid     <= 1'b0;
      sample       <= '0;
      sample_valid <= 1'b0;
    end else begin
      if (tick) s1_amp <= amp;
      s2_amp       <= s1_amp;
      s3_amp       <= s2_amp;
      s4_amp       <= s3_amp;
      s4_sample    <= s_signed;
      s4_valid     <= s3_valid;
      if (s4_valid) sample <= prod[BITSIZE+7:8];
      sample_valid <= s4_valid;
    end
  end

  // S5: selecting bits [BITSIZE+7:8] of the signed product is the arithmetic >>> 8 (floor).
  assign s_ext = {{9{s4_sample[BITSIZE-1]}}, s4_sample};
  assign a_ext = {{(BITSIZE + 1){1'b0}}, s4_amp};
  assign prod  = s_ext * a_ext;
  assign unused_prod_bits = ^{prod[BITSIZE+8], prod[7:0]};
`else
  logic unused_amp;
  assign unused_amp = ^amp;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sample       <= '0;
      sample_valid <= 1'b0;
    end else begin
      if (s3_valid) sample <= s_signed;
      sample_valid <= s3_valid;
    end
  end
`endif

endmodule

// File: tb/tb_sine_nco.sv
// Directed bench for sine_nco; expected values follow SINE_NCO_AMP_EN when it is defined.
module tb_sine_nco;

`ifdef SINE_NCO_AMP_EN
  localparam int LAT = 5;
  localparam int V0 = 100, V1 = 32639, V2 = -101, V3 = -32640;
  localparam int H0 = 50,  H1 = 16383, H2 = -51,  H3 = -16384;
`else
  localparam int LAT = 4;
  localparam int V0 = 101, V1 = 32767, V2 = -101, V3 = -32767;
  localparam int H0 = 101, H1 = 32767, H2 = -101, H3 = -32767;
`endif
  localparam logic [23:0] STEP_Q = 24'h40_0000;
  localparam logic [23:0] STEP_H = 24'h80_0000;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               lrclk = 1'b0;
  logic               phase_clr = 1'b0;
  logic [23:0]        freq_word = '0;
  logic [7:0]         amp = 8'd255;
  logic signed [15:0] sample;
  logic               sample_valid;

  int n_checks = 0;
  int n_fail   = 0;

  sine_nco #(.BITSIZE(16), .PHASE_BITS(24), .LUT_BITS(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .lrclk        (lrclk),
    .freq_word    (freq_word),
    .amp          (amp),
    .phase_clr    (phase_clr),
    .sample       (sample),
    .sample_valid (sample_valid)
  );

  always #5 clk = ~clk;

  // One lrclk pulse, then a fixed 12-cycle window; k counts edges after E0.
  task automatic run_tick(output int got, output int lat, output int nvalid);
    got = 0; lat = -1; nvalid = 0;
    @(negedge clk); lrclk = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 0) lrclk = 1'b0;
      if (sample_valid === 1'b1) begin
        nvalid++;
        if (lat < 0) begin lat = k; got = int'(sample); end
      end
    end
  endtask

  task automatic test_reset();
    int nv = 0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (sample !== 16'sd0) begin n_fail++; $display("FAIL reset_sample: got %0d want 0", sample); end
    n_checks++;
    if (sample_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", sample_valid); end
    rst = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (sample_valid !== 1'b0) nv++;
    end
    n_checks++;
    if (nv != 0) begin n_fail++; $display("FAIL idle_after_reset: got %0d pulses want 0", nv); end
  endtask

  task automatic test_single();
    int got, lat, nv;
    freq_word = '0; amp = 8'd255;
    run_tick(got, lat, nv);
    n_checks++;
    if (lat != LAT) begin n_fail++; $display("FAIL latency: got %0d want %0d", lat, LAT); end
    n_checks++;
    if (got != V0) begin n_fail++; $display("FAIL single_sample: got %0d want %0d", got, V0); end
    n_checks++;
    if (nv != 1) begin n_fail++; $display("FAIL valid_pulse: got %0d pulses want 1", nv); end
    run_tick(got, lat, nv);
    n_checks++;
    if (got != V0) begin n_fail++; $display("FAIL freq0_constant: got %0d want %0d", got, V0); end
  endtask

  task automatic test_quadrants();
    int got, lat, nv;
    int exp_q[5] = '{V0, V1, V2, V3, V0};
    freq_word = STEP_Q; amp = 8'd255;
    for (int i = 0; i < 5; i++) begin
      phase_clr = (i == 0);
      run_tick(got, lat, nv);
      n_checks++;
      if (got != exp_q[i] || nv != 1) begin
        n_fail++; $display("FAIL quadrant_%0d: got %0d (%0d pulses) want %0d", i, got, nv, exp_q[i]);
      end
    end
    phase_clr = 1'b0;
  endtask

  // The step change only shows one tick later; garbage between ticks must be ignored.
  task automatic test_freq_change();
    int got, lat, nv;
    int exp_f[5] = '{V0, V1, V2, V0, V2};
    amp = 8'd255;
    for (int i = 0; i < 5; i++) begin
      phase_clr = (i == 0);
      freq_word = (i < 2) ? STEP_Q : STEP_H;
      if (i == 3) begin
        freq_word = 24'h5A_5A5A;
        repeat (3) @(negedge clk);
        freq_word = STEP_H;
      end
      run_tick(got, lat, nv);
      n_checks++;
      if (got != exp_f[i]) begin n_fail++; $display("FAIL freq_change_%0d: got %0d want %0d", i, got, exp_f[i]); end
    end
    phase_clr = 1'b0;
  endtask

  task automatic test_phase_clr();
    int got, lat, nv;
    int exp_c[3] = '{V0, V1, V2};
    freq_word = STEP_Q; amp = 8'd255;
    run_tick(got, lat, nv);
    for (int i = 0; i < 3; i++) begin
      phase_clr = (i == 0);
      run_tick(got, lat, nv);
      n_checks++;
      if (got != exp_c[i]) begin n_fail++; $display("FAIL phase_clr_%0d: got %0d want %0d", i, got, exp_c[i]); end
    end
    phase_clr = 1'b0;
  endtask

  task automatic test_amp();
    int got, lat, nv;
    int exp_a[4] = '{H0, H1, H2, H3};
    freq_word = STEP_Q; amp = 8'd128;
    for (int i = 0; i < 4; i++) begin
      phase_clr = (i == 0);
      run_tick(got, lat, nv);
      n_checks++;
      if (got != exp_a[i]) begin n_fail++; $display("FAIL amp_half_%0d: got %0d want %0d", i, got, exp_a[i]); end
    end
    phase_clr = 1'b0; amp = 8'd255;
  endtask

  // Ticks every other cycle so several samples are in flight at once.
  task automatic test_back_to_back();
    int got_q[$];
    int exp_b[4] = '{V0, V1, V2, V3};
    freq_word = STEP_Q; amp = 8'd255; phase_clr = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (sample_valid === 1'b1) got_q.push_back(int'(sample));
      lrclk = (k < 8) && (k % 2 == 0);
      if (k == 2) phase_clr = 1'b0;
    end
    n_checks++;
    if (got_q.size() != 4) begin n_fail++; $display("FAIL b2b_count: got %0d want 4", got_q.size()); end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] != exp_b[i]) begin n_fail++; $display("FAIL b2b_%0d: got %0d want %0d", i, got_q[i], exp_b[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int got, lat, nv;
    int pulses = 0;
    freq_word = STEP_Q; amp = 8'd255;
    @(negedge clk); lrclk = 1'b1;
    @(negedge clk);
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (sample_valid !== 1'b0) pulses++;
    end
    n_checks++;
    if (sample !== 16'sd0) begin n_fail++; $display("FAIL mid_reset_sample: got %0d want 0", sample); end
    rst = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (sample_valid !== 1'b0) pulses++;
    end
    n_checks++;
    if (pulses != 0) begin n_fail++; $display("FAIL mid_reset_pulses: got %0d want 0", pulses); end
    n_checks++;
    if (sample !== 16'sd0) begin n_fail++; $display("FAIL held_high_sample: got %0d want 0", sample); end
    lrclk = 1'b0;
    @(negedge clk);
    run_tick(got, lat, nv);
    n_checks++;
    if (got != V0 || lat != LAT) begin
      n_fail++; $display("FAIL after_reset_tick: got %0d lat %0d want %0d lat %0d", got, lat, V0, LAT);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_quadrants();
    test_freq_change();
    test_phase_clr();
    test_amp();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
